// File: rtl/uart_rx_pkt_ctrl.sv
// Frames SYNC/LEN/payload/CHK packets from the UART byte stream, verifies them and holds the payload for a consumer.
// Optional inter-byte timeout is built only when UART_PKT_TIMEOUT_EN is defined.
module uart_rx_pkt_ctrl #(
    parameter int         MAX_LEN     = 16,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 100000,
    parameter int         LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_done,
    output logic             pkt_valid,
    output logic [LEN_W-1:0] pkt_len,
    input  logic             pkt_ack,
    input  logic [LEN_W-1:0] pkt_rd_addr,
    output logic [7:0]       pkt_rd_data,
    output logic             err_chk,
    output logic             err_len,
    output logic             err_ovr,
    output logic             err_timeout,
    output logic             busy
);
    localparam int               IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_HOLD} state_t;

    state_t     state, state_n;
    logic       rx_done_q;
    logic       ev;
    logic       timeout_hit;
    logic [7:0] len_q;
    logic [7:0] sum;
    logic [7:0] idx;
    logic       err_chk_n, err_len_n, err_ovr_n;
    logic [7:0] pkt_buf [0:MAX_LEN-1];

    assign ev = rx_done & ~rx_done_q;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (ev && rx_data == SYNC_BYTE) state_n = S_LEN;
            end
            S_LEN: begin
                if (ev) begin
                    if (rx_data > MAX_LEN_B)  state_n = S_IDLE;
                    else if (rx_data == 8'd0) state_n = S_CHK;
                    else                      state_n = S_PAYLOAD;
                end else if (timeout_hit) begin
                    state_n = S_IDLE;
                end
            end
            S_PAYLOAD: begin
                if (ev) begin
                    if (idx == len_q - 8'd1) state_n = S_CHK;
                end else if (timeout_hit) begin
                    state_n = S_IDLE;
                end
            end
            S_CHK: begin
                if (ev)               state_n = (rx_data == sum) ? S_HOLD : S_IDLE;
                else if (timeout_hit) state_n = S_IDLE;
            end
            S_HOLD: begin
                // Release and a new SYNC in the same cycle chain straight into LEN.
                if (pkt_ack) state_n = (ev && rx_data == SYNC_BYTE) ? S_LEN : S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
        pkt_valid = (state == S_HOLD);
        err_len_n = ev && (state == S_LEN) && (rx_data > MAX_LEN_B);
        err_chk_n = ev && (state == S_CHK) && (rx_data != sum);
        err_ovr_n = ev && (state == S_HOLD) && !pkt_ack;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_done_q   <= 1'b0;
            len_q       <= 8'd0;
            sum         <= 8'd0;
            idx         <= 8'd0;
            pkt_len     <= '0;
            pkt_rd_data <= 8'd0;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_ovr     <= 1'b0;
        end else begin
            rx_done_q   <= rx_done;
            err_chk     <= err_chk_n;
            err_len     <= err_len_n;
            err_ovr     <= err_ovr_n;
            pkt_rd_data <= (pkt_rd_addr < MAX_LEN_L) ? pkt_buf[pkt_rd_addr[IDX_W-1:0]] : 8'h00;
            if (ev) begin
                case (state)
                    S_LEN: begin
                        len_q <= rx_data;
                        sum   <= rx_data;
                        idx   <= 8'd0;
                    end
                    S_PAYLOAD: begin
                        sum <= sum + rx_data;
                        idx <= idx + 8'd1;
                    end
                    S_CHK: begin
                        if (rx_data == sum) pkt_len <= len_q[LEN_W-1:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Payload storage has no reset; stale bytes beyond pkt_len remain readable.
    always_ff @(posedge clk) begin
        if (!reset && ev && state == S_PAYLOAD) pkt_buf[idx[IDX_W-1:0]] <= rx_data;
    end

`ifdef UART_PKT_TIMEOUT_EN
    localparam int           TO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] to_cnt;

    assign timeout_hit = busy && !ev && (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= timeout_hit;
            if (ev || !busy) to_cnt <= '0;
            else             to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign timeout_hit        = 1'b0;
    assign err_timeout        = 1'b0;
`endif
endmodule
